// File: rtl/elevator_scan_controller.sv
// Elevator SCAN controller: latches hall/car calls, serves them in the
// current travel direction before reversing, with door dwell, emergency
// stop and power-off handling.
// Optional build macro ELEVATOR_OVERLOAD_HOLD_EN: weight overload holds
// the door open and blocks departure from IDLE.
module elevator_scan_controller #(
    parameter int NUM_FLOORS    = 11,
    parameter int FLOOR_BITS    = 4,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_call_buttons,
    input  logic [NUM_FLOORS-1:0] panel_buttons,
    input  logic                  door_open_btn,
    input  logic                  door_close_btn,
    input  logic                  emergency_btn,
    input  logic                  power_switch,
    input  logic                  weight_sensor,
    output logic [NUM_FLOORS-1:0] call_button_lights,
    output logic [NUM_FLOORS-1:0] panel_button_lights,
    output logic [FLOOR_BITS-1:0] current_floor,
    output logic                  door_open,
    output logic                  moving,
    output logic                  up_lamp,
    output logic                  down_lamp,
    output logic                  alarm,
    output logic                  weight_overload_lamp,
    output logic [2:0]            elevator_state
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_DOOR  = 3'd3;
    localparam logic [2:0] S_EMERG = 3'd4;

    localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES);

    logic [2:0]            r_state;
    logic [FLOOR_BITS-1:0] r_floor;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_call;
    logic [NUM_FLOORS-1:0] r_panel;
    logic [7:0]            r_travel;
    logic [7:0]            r_door_tmr;
    logic                  r_aborted;   // EMERG entered while the car was travelling

    logic [NUM_FLOORS-1:0] w_pending;
    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_ahead_nf;
    logic [NUM_FLOORS-1:0] w_cur_oh;
    logic [NUM_FLOORS-1:0] w_nf_oh;
    logic [NUM_FLOORS-1:0] w_clr_mask;
    logic [NUM_FLOORS-1:0] w_btn_mask;
    logic [NUM_FLOORS-1:0] w_call_next;
    logic [NUM_FLOORS-1:0] w_panel_next;
    logic [FLOOR_BITS-1:0] w_next_floor;
    logic                  w_pend_cur;
    logic                  w_pend_nf;
    logic                  w_cur_btn;
    logic                  w_dir_any;
    logic                  w_step;
    logic                  w_normal;
    logic                  w_enter_door;
    logic                  w_lights_off;
    logic                  w_can_move;

    assign w_pending    = r_call | r_panel;
    assign w_next_floor = r_dir_up ? (r_floor + FLOOR_BITS'(1)) : (r_floor - FLOOR_BITS'(1));

    // Floor masks relative to the current floor and to the floor one step ahead
    always_comb begin
        w_above    = '0;
        w_below    = '0;
        w_ahead_nf = '0;
        w_cur_oh   = '0;
        w_nf_oh    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_cur_oh[i]   = (FLOOR_BITS'(i) == r_floor);
            w_nf_oh[i]    = (FLOOR_BITS'(i) == w_next_floor);
            w_above[i]    = w_pending[i] & (FLOOR_BITS'(i) > r_floor);
            w_below[i]    = w_pending[i] & (FLOOR_BITS'(i) < r_floor);
            w_ahead_nf[i] = w_pending[i] & (r_dir_up ? (FLOOR_BITS'(i) > w_next_floor)
                                                     : (FLOOR_BITS'(i) < w_next_floor));
        end
    end

    assign w_pend_cur = |(w_pending & w_cur_oh);
    assign w_pend_nf  = |(w_pending & w_nf_oh);
    assign w_cur_btn  = |((floor_call_buttons | panel_buttons) & w_cur_oh);
    // Stepping is only allowed toward a pending floor, so the car never leaves 0..NUM_FLOORS-1
    assign w_dir_any  = r_dir_up ? (|w_above) : (|w_below);
    assign w_step     = (r_state == S_MOVE) && (r_travel == TRAVEL_LAST) && w_dir_any;
    assign w_normal   = power_switch && !emergency_btn;

    assign w_enter_door = w_normal && (((r_state == S_IDLE) && w_pend_cur) || (w_step && w_pend_nf));
    assign w_clr_mask   = w_enter_door ? ((r_state == S_MOVE) ? w_nf_oh : w_cur_oh) : '0;
    // While the door is open at a floor, that floor's buttons are consumed, not latched
    assign w_btn_mask   = (r_state == S_DOOR) ? ~w_cur_oh : '1;
    assign w_lights_off = !power_switch || (r_state == S_OFF);
    assign w_call_next  = w_lights_off ? '0 : ((r_call  | (floor_call_buttons & w_btn_mask)) & ~w_clr_mask);
    assign w_panel_next = w_lights_off ? '0 : ((r_panel | (panel_buttons      & w_btn_mask)) & ~w_clr_mask);

`ifdef ELEVATOR_OVERLOAD_HOLD_EN
    assign w_can_move = !weight_sensor;
`else
    assign w_can_move = 1'b1;
`endif

    // Request latches, position, direction and the controller FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_floor    <= '0;
            r_dir_up   <= 1'b1;
            r_call     <= '0;
            r_panel    <= '0;
            r_travel   <= '0;
            r_door_tmr <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_call  <= w_call_next;
            r_panel <= w_panel_next;
            if (!power_switch) begin
                r_state    <= S_OFF;
                r_travel   <= '0;
                r_door_tmr <= '0;
                r_aborted  <= 1'b0;
            end else if (emergency_btn) begin
                r_state    <= S_EMERG;
                r_travel   <= '0;
                r_door_tmr <= '0;
                if (r_state == S_MOVE)
                    r_aborted <= 1'b1;
                else if (r_state != S_EMERG)
                    r_aborted <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: r_state <= S_IDLE;
                    S_EMERG: begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b0;
                    end
                    S_IDLE: begin
                        if (w_pend_cur) begin
                            r_state    <= S_DOOR;
                            r_door_tmr <= DOOR_LOAD;
                        end else if (w_can_move) begin
                            if (r_dir_up ? (|w_above) : (|w_below)) begin
                                r_state <= S_MOVE;
                            end else if (|w_above) begin
                                r_state  <= S_MOVE;
                                r_dir_up <= 1'b1;
                            end else if (|w_below) begin
                                r_state  <= S_MOVE;
                                r_dir_up <= 1'b0;
                            end
                        end
                    end
                    S_MOVE: begin
                        if (!w_dir_any) begin
                            r_state  <= S_IDLE;
                            r_travel <= '0;
                        end else if (w_step) begin
                            r_travel <= '0;
                            r_floor  <= w_next_floor;
                            if (w_pend_nf) begin
                                r_state    <= S_DOOR;
                                r_door_tmr <= DOOR_LOAD;
                            end else if (!(|w_ahead_nf)) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_travel <= r_travel + 8'd1;
                        end
                    end
                    S_DOOR: begin
`ifdef ELEVATOR_OVERLOAD_HOLD_EN
                        if (weight_sensor)
                            r_door_tmr <= DOOR_LOAD;
                        else
`endif
                        if (door_open_btn || w_cur_btn)
                            r_door_tmr <= DOOR_LOAD;
                        else if (door_close_btn || (r_door_tmr <= 8'd1)) begin
                            r_state    <= S_IDLE;
                            r_door_tmr <= '0;
                        end else
                            r_door_tmr <= r_door_tmr - 8'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign call_button_lights   = r_call;
    assign panel_button_lights  = r_panel;
    assign current_floor        = r_floor;
    assign elevator_state       = r_state;
    assign door_open            = (r_state == S_DOOR) || ((r_state == S_EMERG) && !r_aborted);
    assign moving               = (r_state == S_MOVE);
    assign up_lamp              = (r_state == S_MOVE) && r_dir_up;
    assign down_lamp            = (r_state == S_MOVE) && !r_dir_up;
    assign alarm                = (r_state == S_EMERG);
    assign weight_overload_lamp = weight_sensor;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed scenarios plus randomized
// traffic, every cycle compared against a rule-level reference model.
module tb_elevator_scan_controller;

    localparam int NF = 11;
    localparam int FB = 4;
    localparam int TC = 4;
    localparam int DC = 6;

    logic          clock, reset;
    logic [NF-1:0] call_b, panel_b;
    logic          open_b, close_b, emerg_b, power_b, weight_b;
    logic [NF-1:0] call_lt, panel_lt;
    logic [FB-1:0] floor_o;
    logic          door_o, moving_o, up_o, down_o, alarm_o, wlamp_o;
    logic [2:0]    state_o;

    elevator_scan_controller #(
        .NUM_FLOORS(NF), .FLOOR_BITS(FB), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clock(clock), .reset(reset),
        .floor_call_buttons(call_b), .panel_buttons(panel_b),
        .door_open_btn(open_b), .door_close_btn(close_b),
        .emergency_btn(emerg_b), .power_switch(power_b), .weight_sensor(weight_b),
        .call_button_lights(call_lt), .panel_button_lights(panel_lt),
        .current_floor(floor_o), .door_open(door_o), .moving(moving_o),
        .up_lamp(up_o), .down_lamp(down_o), .alarm(alarm_o),
        .weight_overload_lamp(wlamp_o), .elevator_state(state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode uses the published state numbering
    // (0 off, 1 idle, 2 travel, 3 door, 4 emergency).
    int m_mode, m_fl, m_prog, m_left;
    bit m_up, m_abort;
    bit m_call[NF];
    bit m_panel[NF];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit wanted(int f);
        return m_call[f] | m_panel[f];
    endfunction

    // Any request strictly beyond floor f in the given direction
    function automatic bit any_beyond(int f, bit up);
        for (int j = 0; j < NF; j++)
            if (wanted(j) && (up ? (j > f) : (j < f))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] pack(input bit a[NF]);
        logic [NF-1:0] v;
        for (int j = 0; j < NF; j++) v[j] = a[j];
        return v;
    endfunction

    task automatic model_step();
        int mode, fl, prog, left, door_at;
        bit up, ab, can_go, at_btn;
        bit nc[NF];
        bit np[NF];
        mode = m_mode; fl = m_fl; prog = m_prog; left = m_left;
        up = m_up; ab = m_abort; door_at = -1;
        nc = m_call; np = m_panel;
        if (reset) begin
            mode = 1; fl = 0; up = 1; prog = 0; left = 0; ab = 0;
            for (int f = 0; f < NF; f++) begin nc[f] = 0; np[f] = 0; end
        end else begin
            for (int f = 0; f < NF; f++) begin
                if (!power_b || m_mode == 0) begin
                    nc[f] = 0; np[f] = 0;
                end else if (!(m_mode == 3 && f == m_fl)) begin
                    if (call_b[f])  nc[f] = 1;
                    if (panel_b[f]) np[f] = 1;
                end
            end
            if (!power_b) begin
                mode = 0; prog = 0; left = 0; ab = 0;
            end else if (emerg_b) begin
                mode = 4; prog = 0; left = 0;
                ab = (m_mode == 2) ? 1'b1 : ((m_mode == 4) ? m_abort : 1'b0);
            end else begin
                case (m_mode)
                    0: mode = 1;
                    4: begin mode = 1; ab = 0; end
                    1: begin
`ifdef ELEVATOR_OVERLOAD_HOLD_EN
                        can_go = !weight_b;
`else
                        can_go = 1'b1;
`endif
                        if (wanted(m_fl)) begin
                            mode = 3; left = DC; door_at = m_fl;
                        end else if (can_go) begin
                            if (any_beyond(m_fl, m_up)) mode = 2;
                            else if (any_beyond(m_fl, !m_up)) begin mode = 2; up = !m_up; end
                        end
                    end
                    2: begin
                        if (m_prog == TC - 1) begin
                            prog = 0;
                            fl = m_up ? m_fl + 1 : m_fl - 1;
                            if (wanted(fl)) begin mode = 3; left = DC; door_at = fl; end
                            else if (!any_beyond(fl, m_up)) mode = 1;
                        end else prog = m_prog + 1;
                    end
                    3: begin
                        at_btn = call_b[m_fl] | panel_b[m_fl];
`ifdef ELEVATOR_OVERLOAD_HOLD_EN
                        if (weight_b) left = DC; else
`endif
                        if (open_b || at_btn) left = DC;
                        else if (close_b || m_left <= 1) begin mode = 1; left = 0; end
                        else left = m_left - 1;
                    end
                    default: mode = 1;
                endcase
            end
            if (door_at >= 0) begin nc[door_at] = 0; np[door_at] = 0; end
        end
        m_mode = mode; m_fl = fl; m_prog = prog; m_left = left;
        m_up = up; m_abort = ab; m_call = nc; m_panel = np;
    endtask

    task automatic compare_all();
        check("state",     32'(state_o),  32'(m_mode));
        check("floor",     32'(floor_o),  32'(m_fl));
        check("call_lt",   32'(call_lt),  32'(pack(m_call)));
        check("panel_lt",  32'(panel_lt), 32'(pack(m_panel)));
        check("door_open", 32'(door_o),   32'(m_mode == 3 || (m_mode == 4 && !m_abort)));
        check("moving",    32'(moving_o), 32'(m_mode == 2));
        check("up_lamp",   32'(up_o),     32'(m_mode == 2 && m_up));
        check("down_lamp", 32'(down_o),   32'(m_mode == 2 && !m_up));
        check("alarm",     32'(alarm_o),  32'(m_mode == 4));
        check("wt_lamp",   32'(wlamp_o),  32'(weight_b));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        while (32'(state_o) != s && n < budget) begin tick(); n++; end
        check(tag, 32'(state_o), s);
    endtask

    task automatic wait_floor(input int f, input int budget, input string tag);
        int n = 0;
        while (32'(floor_o) != f && n < budget) begin tick(); n++; end
        check(tag, 32'(floor_o), f);
    endtask

    task automatic door_len(input int want, input string tag);
        int n = 0;
        while (door_o === 1'b1 && n < 40) begin n++; tick(); end
        check(tag, n, want);
    endtask

    initial begin
        int eb, pb;
        call_b = '0; panel_b = '0; open_b = 0; close_b = 0;
        emerg_b = 0; power_b = 1; weight_b = 0; reset = 0;
        m_mode = 1; m_fl = 0; m_prog = 0; m_left = 0; m_up = 1; m_abort = 0;
        for (int f = 0; f < NF; f++) begin m_call[f] = 0; m_panel[f] = 0; end

        // single request at floor 3
        do_reset();
        check("rst_state", 32'(state_o), 1);
        check("rst_floor", 32'(floor_o), 0);
        check("rst_lights", 32'(call_lt | panel_lt), 0);
        check("rst_door", 32'(door_o), 0);
        panel_b[3] = 1; tick(); panel_b = '0;
        check("s1_latch", 32'(panel_lt[3]), 1);
        tick();
        check("s1_move", 32'(state_o), 2);
        check("s1_up", 32'(up_o), 1);
        repeat (12) tick();
        check("s1_floor3", 32'(floor_o), 3);
        check("s1_door", 32'(state_o), 3);
        check("s1_clear", 32'(panel_lt[3]), 0);
        door_len(6, "s1_door_len");
        check("s1_idle", 32'(state_o), 1);

        // SCAN ordering: 2, 5, then 1 going down
        do_reset();
        call_b[2] = 1; call_b[5] = 1; tick(); call_b = '0;
        wait_state(3, 60, "s2_door_a");
        check("s2_at2", 32'(floor_o), 2);
        wait_state(2, 40, "s2_move_b");
        wait_floor(3, 40, "s2_mid");
        call_b[1] = 1; tick(); call_b = '0;
        wait_state(3, 60, "s2_door_b");
        check("s2_at5", 32'(floor_o), 5);
        wait_state(2, 40, "s2_move_c");
        check("s2_down", 32'(down_o), 1);
        wait_state(3, 60, "s2_door_c");
        check("s2_at1", 32'(floor_o), 1);

        // emergency on the second travel clock
        do_reset();
        panel_b[4] = 1; tick(); panel_b = '0;
        tick();
        check("s3_move", 32'(state_o), 2);
        tick();
        emerg_b = 1; tick();
        check("s3_emerg", 32'(state_o), 4);
        check("s3_alarm", 32'(alarm_o), 1);
        check("s3_door_shut", 32'(door_o), 0);
        check("s3_floor", 32'(floor_o), 0);
        repeat (3) tick();
        check("s3_kept", 32'(panel_lt[4]), 1);
        emerg_b = 0; tick();
        check("s3_idle", 32'(state_o), 1);
        tick();
        check("s3_resume", 32'(state_o), 2);
        wait_state(3, 60, "s3_door");
        check("s3_at4", 32'(floor_o), 4);

        // door close / open+close reload
        do_reset();
        panel_b[0] = 1; tick(); panel_b = '0; tick();
        check("s4_door", 32'(state_o), 3);
        close_b = 1; tick(); close_b = 0;
        check("s4_closed", 32'(state_o), 1);
        panel_b[0] = 1; tick(); panel_b = '0; tick();
        tick(); tick();
        open_b = 1; close_b = 1; tick(); open_b = 0; close_b = 0;
        check("s4_open_wins", 32'(state_o), 3);
        door_len(6, "s4_reload_len");

        // power off clears everything
        do_reset();
        call_b[2] = 1; panel_b[5] = 1; tick(); call_b = '0; panel_b = '0;
        check("s5_lights", 32'(call_lt | panel_lt), 32'h024);
        power_b = 0; tick();
        check("s5_off", 32'(state_o), 0);
        check("s5_dark", 32'(call_lt | panel_lt), 0);
        call_b = '1; emerg_b = 1; tick(); call_b = '0; emerg_b = 0;
        check("s5_ignore", 32'(call_lt | panel_lt), 0);
        check("s5_off_pri", 32'(state_o), 0);
        power_b = 1; tick();
        check("s5_on", 32'(state_o), 1);

`ifdef ELEVATOR_OVERLOAD_HOLD_EN
        do_reset();
        weight_b = 1;
        panel_b[0] = 1; tick(); panel_b = '0; tick();
        close_b = 1; repeat (30) tick(); close_b = 0;
        check("s6_hold", 32'(state_o), 3);
        weight_b = 0;
`endif

        // randomized traffic against the model
        do_reset();
        eb = 0; pb = 0;
        for (int c = 0; c < 3000; c++) begin
            call_b = '0; panel_b = '0;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) call_b[$urandom_range(0, NF-1)] = 1;
                else panel_b[$urandom_range(0, NF-1)] = 1;
            end
            open_b  = ($urandom_range(0, 39) == 0);
            close_b = ($urandom_range(0, 24) == 0);
            weight_b = ($urandom_range(0, 3) == 0);
            if (eb == 0 && $urandom_range(0, 249) == 0) eb = $urandom_range(1, 8);
            if (pb == 0 && $urandom_range(0, 499) == 0) pb = $urandom_range(1, 5);
            emerg_b = (eb != 0);
            power_b = (pb == 0);
            if (eb != 0) eb--;
            if (pb != 0) pb--;
            reset = ($urandom_range(0, 1499) == 0);
            tick();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
